uart_result_tx: RTL

- Parametrised successor to the top-level single-byte UART result path (`tx_data`).
- Accepts result words of configurable width from the inference/DDR2 readback logic through a valid/ready handshake.
- Buffers words in an internal FIFO and serialises each one as a sequence of 8N1 UART frames, least-significant byte first.
- Sits inside FPGA_top between result producers and the `tx_data` pin; gated by the board-level `enb`.

---
 rtl/uart_result_tx.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_result_tx.sv
// uart_result_tx
//   Buffers result words in a small FIFO and sends each one over a UART line.
//   Each word goes out least-significant byte first, one frame per byte.
//   The frames of one word follow each other with no idle gap.
//   Any pad bits above DATA_W are sent as 0.
//
// Optional build macro:
//   UART_PARITY_EN - adds an even-parity bit after the data bits (8E1 framing).
//                    Without it the framing is plain 8N1.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   enb         transmit enable; a new word is only started while high
//   in_valid    producer presents a word on in_data
//   in_data     result word [DATA_W-1:0]
//   in_ready    FIFO has room this cycle
//   tx_data     UART serial output, idle high
//   busy        a word is being transmitted
//   fifo_count  number of buffered words [COUNT_W-1:0]
//   overflow    sticky flag: a word was offered while the FIFO was full
module uart_result_tx #(
    parameter int DATA_W       = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int COUNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enb,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic               tx_data,
    output logic               busy,
    output logic [COUNT_W-1:0] fifo_count,
    output logic               overflow
);

    localparam int BYTES  = (DATA_W + 7) / 8;
    localparam int SH_W   = BYTES * 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [BAUD_W-1:0]  BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0]  BYTE_LAST = BYTE_W'(BYTES - 1);
    localparam logic [COUNT_W-1:0] DEPTH_C   = COUNT_W'(FIFO_DEPTH);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0]  byte_idx_q, byte_idx_d;
    logic [SH_W-1:0]    shift_q, shift_d;
    logic               tx_q, tx_d;
`ifdef UART_PARITY_EN
    logic               par_q, par_d;
`endif

    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               overflow_q, overflow_d;

    logic push;
    logic pop;

    // in_ready depends only on registered occupancy, so a pop in the same
    // cycle never re-opens a full FIFO and there is no path from in_valid.
    assign in_ready   = (count_q < DEPTH_C);
    assign push       = in_valid && in_ready;
    assign tx_data    = tx_q;
    assign busy       = (state_q != S_IDLE);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        overflow_d = overflow_q | (in_valid && (count_q == DEPTH_C));
        case ({push, pop})
            2'b10:   count_d = count_q + COUNT_W'(1);
            2'b01:   count_d = count_q - COUNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // tx_d is the line level for the state being entered, so tx_data changes
    // on the same edge as the state (registered, glitch-free output).
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q + BAUD_W'(1);
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        pop        = 1'b0;
`ifdef UART_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (enb && (count_q != '0)) begin
                    pop        = 1'b1;
                    shift_d    = SH_W'(mem_q[rd_ptr_q]);
                    byte_idx_d = '0;
                    state_d    = S_START;
                    tx_d       = 1'b0;
`ifdef UART_PARITY_EN
                    par_d      = 1'b0;
`endif
                end
            end
            S_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                    tx_d      = shift_q[0];
                end
            end
            S_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    // Shifting right leaves the next byte in the low bits
                    // once all eight bits of the current one are out.
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
`ifdef UART_PARITY_EN
                    par_d   = par_q ^ shift_q[0];
`endif
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = par_q ^ shift_q[0];
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (byte_idx_q != BYTE_LAST) begin
                        byte_idx_d = byte_idx_q + BYTE_W'(1);
                        state_d    = S_START;
                        tx_d       = 1'b0;
`ifdef UART_PARITY_EN
                        par_d      = 1'b0;
`endif
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
`ifdef UART_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
`ifdef UART_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    // Datapath storage carries no reset; it is only consumed under control
    // of the reset pointers and FSM.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule
